// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register sequencer.
// State encoding, direction constants and the default datapath width.
package shift_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter that tracks the remaining shifts of a job.
// `last` flags the final shift so the FSM can leave SHIFT on that cycle.
module shift_seq_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  // Load takes priority over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == CNT_W'(1));

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for a load/shift register.
// Accepts one job per handshake, then drives load, N shift strobes and a
// one-cycle done pulse. Optional feature macro: SHIFT_SEQ_HOLD_EN adds the
// shift_hold input, which pauses shifting while high in SHIFT.
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             sr_load,
  output logic [WIDTH-1:0] sr_d,
  output logic             sr_shift,
  output logic             sr_dir,
  output logic             busy,
  output logic             done
`ifdef SHIFT_SEQ_HOLD_EN
  ,
  input  logic             shift_hold
`endif
);

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(WIDTH);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic [WIDTH-1:0] data_reg;
  logic             dir_reg;
  logic [CNT_W-1:0] eff_count;
  logic [CNT_W-1:0] remaining;
  logic             remaining_last;
  logic             accept;
  logic             hold;
  logic             cnt_enable;

`ifdef SHIFT_SEQ_HOLD_EN
  assign hold = shift_hold;
`else
  assign hold = 1'b0;
`endif

  // Requests above WIDTH would only shift in more zeros, so clamp them.
  assign eff_count = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;
  assign accept    = cmd_valid && cmd_ready;
  // Hold only freezes the count inside SHIFT; it is ignored elsewhere.
  assign cnt_enable = (state_reg == SHIFT) && !hold;

  shift_seq_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .value  (eff_count),
    .enable (cnt_enable),
    .count  (remaining),
    .last   (remaining_last)
  );

  // State register; reset aborts any job without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the job's data and direction at the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      dir_reg  <= DIR_LEFT;
    end else if (accept) begin
      data_reg <= cmd_data;
      dir_reg  <= cmd_dir;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = LOAD;
      LOAD:    state_next = (remaining == '0) ? DONE : SHIFT;
      SHIFT:   if (!hold && remaining_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state; nothing here depends on cmd_*.
  always_comb begin
    cmd_ready = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_d      = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_reg)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = !reset;
      end
      LOAD: begin
        sr_load = 1'b1;
        sr_d    = data_reg;
      end
      SHIFT:   sr_shift = !hold;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Direction is held from the job capture until the next job or reset.
  assign sr_dir = dir_reg;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural 8-bit shift
// register (zero fill) driven by the sr_* outputs.
module tb_shift_reg_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic       sr_load;
  logic [7:0] sr_d;
  logic       sr_shift;
  logic       sr_dir;
  logic       busy;
  logic       done;
  logic       hold_now;

  int n_cmp = 0;
  int n_err = 0;
  int overlap_err = 0;
  logic [7:0] model_q;

  always #5 clk = ~clk;

  shift_reg_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_dir    (cmd_dir),
    .cmd_count  (cmd_count),
    .sr_load    (sr_load),
    .sr_d       (sr_d),
    .sr_shift   (sr_shift),
    .sr_dir     (sr_dir),
    .busy       (busy),
    .done       (done)
`ifdef SHIFT_SEQ_HOLD_EN
    ,
    .shift_hold (hold_now)
`endif
  );

  // Behavioural shift register controlled by the sequencer.
  always @(posedge clk) begin
    if (sr_load) model_q <= sr_d;
    else if (sr_shift) model_q <= sr_dir ? (model_q >> 1) : (model_q << 1);
  end

  // Offers one job and records when load/shift/done appear, in cycles after
  // the accepting edge (cycle 1 = first cycle after acceptance).
  task automatic do_job(input logic [7:0] d, input logic dir, input logic [3:0] n,
                        input int hold_at, input int hold_len,
                        output int wait_cyc, output int load_at, output int done_at,
                        output int shifts, output int loads, output bit timed_out);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_count = n;
    wait_cyc = 0; load_at = -1; done_at = -1; shifts = 0; loads = 0; timed_out = 1'b0;
    while (!cmd_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!cmd_ready) begin
      timed_out = 1'b1;
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    k = 0;
    while (done_at < 0 && k < 40) begin
      @(negedge clk);
      k++;
      cmd_valid = 1'b0;
      hold_now = (k >= hold_at) && (k < hold_at + hold_len);
      #1;
      if (sr_load) begin loads++; load_at = k; end
      if (sr_shift) shifts++;
      if (sr_load && sr_shift) overlap_err++;
      if (hold_now && sr_shift) overlap_err++;
      if (done) done_at = k;
    end
    hold_now = 1'b0;
    timed_out = (done_at < 0);
    $display("job data=%h dir=%0d count=%0d wait=%0d load_at=%0d done_at=%0d shifts=%0d reg=%h",
             d, dir, n, wait_cyc, load_at, done_at, shifts, model_q);
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0; cmd_count = '0; hold_now = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low: got %b expected 0", cmd_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if ({sr_load, sr_shift, sr_dir, sr_d} !== 11'h0) begin n_err++;
      $display("FAIL reset_sr: got %h expected 000", {sr_load, sr_shift, sr_dir, sr_d}); end
  endtask

  task automatic test_shift_left();
    int w, la, da, sh, ld; bit to;
    do_job(8'hFF, 1'b0, 4'd5, 0, 0, w, la, da, sh, ld, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL left_timeout: got timeout expected done"); end
    n_cmp++; if (la !== 1) begin n_err++; $display("FAIL left_load_at: got %0d expected 1", la); end
    n_cmp++; if (sh !== 5) begin n_err++; $display("FAIL left_shifts: got %0d expected 5", sh); end
    n_cmp++; if (da !== 7) begin n_err++; $display("FAIL left_done_at: got %0d expected 7", da); end
    n_cmp++; if (model_q !== 8'hE0) begin n_err++; $display("FAIL left_reg: got %h expected e0", model_q); end
  endtask

  task automatic test_back_to_back();
    int w, la, da, sh, ld; bit to;
    do_job(8'hA8, 1'b1, 4'd3, 0, 0, w, la, da, sh, ld, to);
    n_cmp++; if (da !== 5) begin n_err++; $display("FAIL right_done_at: got %0d expected 5", da); end
    n_cmp++; if (model_q !== 8'h15) begin n_err++; $display("FAIL right_reg: got %h expected 15", model_q); end
    n_cmp++; if (sr_dir !== 1'b1) begin n_err++; $display("FAIL right_dir: got %b expected 1", sr_dir); end
    do_job(8'h81, 1'b0, 4'd1, 0, 0, w, la, da, sh, ld, to);
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL b2b_wait: got %0d expected 0", w); end
    n_cmp++; if (da !== 3) begin n_err++; $display("FAIL b2b_done_at: got %0d expected 3", da); end
    n_cmp++; if (model_q !== 8'h02) begin n_err++; $display("FAIL b2b_reg: got %h expected 02", model_q); end
  endtask

  task automatic test_count_bounds();
    int w, la, da, sh, ld; bit to;
    do_job(8'h5A, 1'b1, 4'd0, 0, 0, w, la, da, sh, ld, to);
    n_cmp++; if (da !== 2) begin n_err++; $display("FAIL zero_done_at: got %0d expected 2", da); end
    n_cmp++; if (sh !== 0) begin n_err++; $display("FAIL zero_shifts: got %0d expected 0", sh); end
    n_cmp++; if (model_q !== 8'h5A) begin n_err++; $display("FAIL zero_reg: got %h expected 5a", model_q); end
    do_job(8'hFF, 1'b0, 4'd12, 0, 0, w, la, da, sh, ld, to);
    n_cmp++; if (sh !== 8) begin n_err++; $display("FAIL clamp_shifts: got %0d expected 8", sh); end
    n_cmp++; if (da !== 10) begin n_err++; $display("FAIL clamp_done_at: got %0d expected 10", da); end
    n_cmp++; if (model_q !== 8'h00) begin n_err++; $display("FAIL clamp_reg: got %h expected 00", model_q); end
    n_cmp++; if (ld !== 1) begin n_err++; $display("FAIL clamp_loads: got %0d expected 1", ld); end
  endtask

  task automatic test_reset_abort();
    int stray;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_dir = 1'b1; cmd_count = 4'd6;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b expected 1", cmd_ready); end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if (sr_load !== 1'b1) begin n_err++; $display("FAIL abort_load: got %b expected 1", sr_load); end
    stray = 0;
    // cmd_valid stays high through the shifts; it must not start anything.
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      #1;
      if (sr_load || cmd_ready || done) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL busy_ignore: got %0d stray cycles expected 0", stray); end
    n_cmp++; if (sr_shift !== 1'b1) begin n_err++; $display("FAIL abort_third_shift: got %b expected 1", sr_shift); end
    reset = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    n_cmp++; if ({busy, done, sr_load, sr_shift, sr_dir, sr_d, cmd_ready} !== 14'h0) begin n_err++;
      $display("FAIL abort_outputs: got %h expected 0000", {busy, done, sr_load, sr_shift, sr_dir, sr_d, cmd_ready}); end
    reset = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready_release: got %b expected 1", cmd_ready); end
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (done || sr_load || busy) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles expected 0", stray); end
    $display("job data=ff dir=1 count=6 aborted by reset in third shift cycle");
  endtask

`ifdef SHIFT_SEQ_HOLD_EN
  task automatic test_hold();
    int w, la, da, sh, ld; bit to;
    do_job(8'hFF, 1'b0, 4'd4, 3, 2, w, la, da, sh, ld, to);
    n_cmp++; if (sh !== 4) begin n_err++; $display("FAIL hold_shifts: got %0d expected 4", sh); end
    n_cmp++; if (da !== 8) begin n_err++; $display("FAIL hold_done_at: got %0d expected 8", da); end
    n_cmp++; if (model_q !== 8'hF0) begin n_err++; $display("FAIL hold_reg: got %h expected f0", model_q); end
  endtask
`endif

  initial begin
    test_reset();
    test_shift_left();
    test_back_to_back();
    test_count_bounds();
    test_reset_abort();
`ifdef SHIFT_SEQ_HOLD_EN
    test_hold();
`endif
    n_cmp++; if (overlap_err !== 0) begin n_err++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command-driven controller that sequences an 8-bit-class shift-left/right load register. It accepts one shift job per valid/ready handshake: parallel data, direction and shift count. It then drives the register's load, shift and direction controls cycle by cycle and pulses `done` when the job completes. It sits between a host or control FSM and the shift-register datapath, so that no requester has to hand-toggle load/shift lines.

## Interface
- `WIDTH`, default 8: datapath width in bits; must be ≥2.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the shift-count field.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a job is offered.
- `cmd_ready` out 1: the sequencer can accept a job.
- `cmd_data` in WIDTH: parallel value to load.
- `cmd_dir` in 1: 0 = shift left, 1 = shift right.
- `cmd_count` in CNT_W: number of single-bit shifts after the load.
- `sr_load` out 1: parallel-load strobe to the register.
- `sr_d` out WIDTH: parallel data to the register. Valid while `sr_load` = 1.
- `sr_shift` out 1: shift-by-one strobe to the register.
- `sr_dir` out 1: shift direction to the register. Held for the whole job.
- `busy` out 1: a job is in progress (any state other than IDLE).
- `done` out 1: one-cycle pulse when a job finishes.
- `shift_hold` in 1: present only with `SHIFT_SEQ_HOLD_EN` (see Configuration).

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Encoded as an enum.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`, capture `cmd_data`, `cmd_dir` and the effective count, then go to LOAD.
  - Effective count = min(`cmd_count`, WIDTH). Values above WIDTH are clamped.
- LOAD (exactly 1 cycle):
  - `sr_load` = 1, `sr_d` = captured data, `sr_dir` = captured direction.
  - Go to SHIFT if the count is >0, otherwise go to DONE.
- SHIFT:
  - `sr_shift` = 1 every cycle. The remaining-count register decrements each cycle.
  - On the cycle where remaining = 1, go to DONE.
- DONE (exactly 1 cycle): `done` = 1, `busy` = 1, then go to IDLE.
- `sr_load` and `sr_shift` are never high in the same cycle.
- In IDLE, `sr_shift`, `sr_load` and `done` are all 0.
- `cmd_ready` = 0 in every non-IDLE state. Commands are not queued. `cmd_valid` asserted while busy is ignored until IDLE.
- Reset (asserted in any state, including mid-SHIFT):
  - Next edge forces IDLE and clears the count.
  - Outputs go to: `sr_load`=0, `sr_shift`=0, `sr_dir`=0, `sr_d`=0, `busy`=0, `done`=0.
  - `cmd_ready` is 0 while `reset` is high and 1 from the first cycle after release.
  - An aborted job produces no `done`.
- All outputs are registered or decoded from the registered state. There is no combinational path from `cmd_*` to `sr_*`.

## Timing
- Handshake accepted at edge T.
- `sr_load` is high in cycle T+1.
- Shifts occur in cycles T+2 … T+1+N.
- `done` is high in cycle T+2+N; `cmd_ready` returns to 1 at T+3+N.
- Job length is N+3 cycles including IDLE re-entry. With N=0, `done` is at T+2.
- Back-to-back jobs: a new handshake is possible in the first IDLE cycle after DONE. Throughput is one job per N+3 cycles.

## Configuration
- `SHIFT_SEQ_HOLD_EN` defined:
  - Adds input `shift_hold`.
  - While `shift_hold` = 1 in SHIFT: `sr_shift` = 0, the count is frozen and the state stays SHIFT.
  - `shift_hold` has no effect in IDLE, LOAD or DONE.
  - Latency grows by the number of held SHIFT cycles.
- `SHIFT_SEQ_HOLD_EN` not defined: the port is absent and SHIFT runs uninterrupted.

## Structure
- Package `shift_seq_pkg` holds:
  - State enum `seq_state_t` (IDLE, LOAD, SHIFT, DONE).
  - Direction constants `DIR_LEFT`=0 and `DIR_RIGHT`=1.
  - Default `WIDTH`.
- Sub-module `shift_seq_counter`:
  - Loadable down-counter, CNT_W bits.
  - Inputs: load, value, enable (gated by hold).
  - Outputs: count and `last` (count == 1).
- Top holds the FSM, command capture registers and output decode.

## Test plan
The bench instantiates the sequencer with a behavioural WIDTH=8 shift register (zero fill) driven by `sr_*`.
- Reset release, no command -> `cmd_ready`=1, `busy`=0, `done`=0, `sr_*` all 0.
- `cmd_data`=0xFF, dir=0, count=5 -> `sr_load` at T+1; `sr_shift` for 5 cycles; `done` at T+7; model register = 0xE0.
- `cmd_data`=0xA8, dir=1, count=3 -> `done` at T+5; register = 0x15. Second job issued on the first cycle `cmd_ready`=1 is accepted.
- count=0 with data 0x5A -> load only, `done` at T+2, register = 0x5A. count=12 clamped to 8 -> register = 0x00, `done` at T+10.
- `reset` asserted during the third SHIFT cycle -> next cycle IDLE, all outputs 0, no `done`. `cmd_valid` held high while busy is never accepted.
- With `SHIFT_SEQ_HOLD_EN`: hold=1 for 2 cycles mid-job (0xFF, left, 4) -> only 4 `sr_shift` pulses; `done` at T+8; register = 0xF0.
